rd_req_fifo: RTL and testbench

- Per-master read-request queue sitting directly upstream of the crossbar arbiter controller; one instance per master port.
- Buffers read addresses pushed by the master-side logic and presents the head entry to the arbiter as a show-ahead request (req/addr).
- The arbiter consumes the head entry with a one-cycle rd_en pulse, which it issues one cycle after it samples addr.
- Fixed-depth circular buffer with registered pointers; no combinational path from rd_en to req/addr.

---
 rtl/cross_bar_pkg.sv | 10 +
 rtl/rd_req_fifo_if.sv | 37 +++
 rtl/rd_req_fifo.sv | 82 ++++++++
 tb/tb_rd_req_fifo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cross_bar_pkg.sv
// Shared crossbar constants: default bus widths and read/write command codes.
package cross_bar_pkg;

   parameter int CB_ADDR_W = 32;
   parameter int CB_DATA_W = 32;

   parameter bit READ_OPP  = 1'b0;
   parameter bit WRITE_OPP = 1'b1;

endpackage

// File: rtl/rd_req_fifo_if.sv
// Read-request queue bus: push side from master logic, show-ahead head and pop to the arbiter.
// Handshake: a push is taken on a rising aclk edge when wr_en=1 and full=0; the head (addr)
// is valid whenever req=1 and is removed on a rising aclk edge when rd_en=1 and req=1.
interface rd_req_fifo_if
   import cross_bar_pkg::*;
#(
   parameter int ADDR_W = CB_ADDR_W
);

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              full;
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              rd_en;

   // Driver side: master-side push logic together with the arbiter pop.
   modport master (
      output wr_en,
      output wr_addr,
      input  full,
      input  req,
      input  addr,
      output rd_en
   );

   // Queue side.
   modport slave (
      input  wr_en,
      input  wr_addr,
      output full,
      output req,
      output addr,
      input  rd_en
   );

endinterface

// File: rtl/rd_req_fifo.sv
// Per-master show-ahead read-request FIFO feeding the crossbar arbiter.
// Optional status outputs (count, sticky overflow) are enabled by RD_REQ_FIFO_STATUS_EN.
module rd_req_fifo
   import cross_bar_pkg::*;
#(
   parameter int ADDR_W = CB_ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   rd_req_fifo_if.slave             bus
`ifdef RD_REQ_FIFO_STATUS_EN
   ,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
`endif
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr;
   logic [ADDR_W-1:0] mem [DEPTH];

   logic empty;
   logic full_w;
   logic push_ok;
   logic pop_ok;

   // Flags come only from registered pointers, so rd_en never reaches full/req combinationally.
   assign empty   = (wptr == rptr);
   assign full_w  = (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]) && (wptr[IDX_W] != rptr[IDX_W]);
   assign push_ok = bus.wr_en && !full_w;
   assign pop_ok  = bus.rd_en && !empty;

   assign bus.full = full_w;
   assign bus.req  = !empty;
   assign bus.addr = mem[rptr[IDX_W-1:0]];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_ok) wptr <= wptr + PTR_W'(1);
         if (pop_ok)  rptr <= rptr + PTR_W'(1);
      end
   end

   // Popped entries keep their contents; only the read pointer moves.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push_ok) begin
         mem[wptr[IDX_W-1:0]] <= bus.wr_addr;
      end
   end

`ifdef RD_REQ_FIFO_STATUS_EN
   logic [PTR_W-1:0] count_q;
   logic             overflow_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + PTR_W'(1);
            2'b01:   count_q <= count_q - PTR_W'(1);
            default: count_q <= count_q;
         endcase
         if (bus.wr_en && full_w) overflow_q <= 1'b1;
      end
   end

   assign count    = count_q;
   assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_rd_req_fifo.sv
// Self-checking bench for rd_req_fifo: directed vector table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_rd_req_fifo;

   localparam int AW    = 32;
   localparam int DEPTH = 4;

   logic aclk;
   logic aresetn;

   rd_req_fifo_if #(.ADDR_W(AW)) bus ();

`ifdef RD_REQ_FIFO_STATUS_EN
   logic [2:0] count;
   logic       overflow;
`endif

   rd_req_fifo #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
`ifdef RD_REQ_FIFO_STATUS_EN
      ,
      .count   (count),
      .overflow(overflow)
`endif
   );

   // Clock / reset
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_cmp = 0;
   int n_err = 0;

   logic [AW-1:0] exp_q[$];
   logic          ovf_m;

   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic          re;
      logic          e_req;
      logic          e_full;
      logic          chk_a;
      logic [AW-1:0] e_addr;
      int            e_cnt;
      logic          e_ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic we, input logic [AW-1:0] wa, input logic re,
                      input logic e_req, input logic e_full, input logic chk_a,
                      input logic [AW-1:0] e_addr, input int e_cnt, input logic e_ovf);
      vec_t v;
      v.we = we; v.wa = wa; v.re = re; v.e_req = e_req; v.e_full = e_full;
      v.chk_a = chk_a; v.e_addr = e_addr; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
      vecs.push_back(v);
   endtask

   // Driver: present inputs for one cycle, then sample 1 ns after the edge.
   task automatic drive(input logic we, input logic [AW-1:0] wa, input logic re);
      bus.wr_en   = we;
      bus.wr_addr = wa;
      bus.rd_en   = re;
      @(posedge aclk);
      #1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      exp_q.delete();
      ovf_m = 1'b0;
      #7;
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
   endtask

   // Reference model: FIFO of at most DEPTH entries; full push dropped, empty pop ignored.
   task automatic step_model(input string tag, input logic we, input logic [AW-1:0] wa, input logic re);
      bit was_full, was_empty;
      was_full  = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      drive(we, wa, re);
      if (re && !was_empty) void'(exp_q.pop_front());
      if (we && !was_full)  exp_q.push_back(wa);
      if (we && was_full)   ovf_m = 1'b1;
      chk({tag, ".req"},  AW'(bus.req),  AW'(exp_q.size() != 0));
      chk({tag, ".full"}, AW'(bus.full), AW'(exp_q.size() == DEPTH));
      if (exp_q.size() != 0) chk({tag, ".addr"}, bus.addr, exp_q[0]);
`ifdef RD_REQ_FIFO_STATUS_EN
      chk({tag, ".count"},    AW'(count),    AW'(exp_q.size()));
      chk({tag, ".overflow"}, AW'(overflow), AW'(ovf_m));
`endif
   endtask

   initial begin
      logic [AW-1:0] held;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.rd_en   = 1'b0;
      aresetn     = 1'b0;
      ovf_m       = 1'b0;

      // Reset state while aresetn is held low
      #2;
      chk("rst.req",  AW'(bus.req),  '0);
      chk("rst.full", AW'(bus.full), '0);
      chk("rst.addr", bus.addr,      '0);
`ifdef RD_REQ_FIFO_STATUS_EN
      chk("rst.count",    AW'(count),    '0);
      chk("rst.overflow", AW'(overflow), '0);
`endif
      do_reset();

      // Directed vector table: we, wa, re | req, full, chk_a, addr, count, overflow
      add(1, 32'h10, 0,  1, 0, 1, 32'h10, 1, 0);
      add(0, 32'h0,  1,  0, 0, 0, 32'h0,  0, 0);
      add(1, 32'h1,  0,  1, 0, 1, 32'h1,  1, 0);
      add(1, 32'h2,  0,  1, 0, 1, 32'h1,  2, 0);
      add(1, 32'h3,  0,  1, 0, 1, 32'h1,  3, 0);
      add(1, 32'h4,  0,  1, 1, 1, 32'h1,  4, 0);
      add(1, 32'h5,  0,  1, 1, 1, 32'h1,  4, 1);
      add(0, 32'h0,  1,  1, 0, 1, 32'h2,  3, 1);
      add(0, 32'h0,  1,  1, 0, 1, 32'h3,  2, 1);
      add(0, 32'h0,  1,  1, 0, 1, 32'h4,  1, 1);
      add(0, 32'h0,  1,  0, 0, 0, 32'h0,  0, 1);
      add(1, 32'hA,  1,  1, 0, 1, 32'hA,  1, 1);
      add(0, 32'h0,  1,  0, 0, 0, 32'h0,  0, 1);
      add(1, 32'h21, 0,  1, 0, 1, 32'h21, 1, 1);
      add(1, 32'h22, 0,  1, 0, 1, 32'h21, 2, 1);
      add(1, 32'h23, 0,  1, 0, 1, 32'h21, 3, 1);
      add(1, 32'h24, 0,  1, 1, 1, 32'h21, 4, 1);
      add(1, 32'h9,  1,  1, 0, 1, 32'h22, 3, 1);
      add(0, 32'h0,  1,  1, 0, 1, 32'h23, 2, 1);
      add(0, 32'h0,  1,  1, 0, 1, 32'h24, 1, 1);
      add(0, 32'h0,  1,  0, 0, 0, 32'h0,  0, 1);

      foreach (vecs[i]) begin
         drive(vecs[i].we, vecs[i].wa, vecs[i].re);
         chk($sformatf("vec%0d.req", i),  AW'(bus.req),  AW'(vecs[i].e_req));
         chk($sformatf("vec%0d.full", i), AW'(bus.full), AW'(vecs[i].e_full));
         if (vecs[i].chk_a) chk($sformatf("vec%0d.addr", i), bus.addr, vecs[i].e_addr);
`ifdef RD_REQ_FIFO_STATUS_EN
         chk($sformatf("vec%0d.count", i),    AW'(count),    AW'(vecs[i].e_cnt));
         chk($sformatf("vec%0d.overflow", i), AW'(overflow), AW'(vecs[i].e_ovf));
`endif
      end

      // Wrap-around: one standing entry, then 10 push/pop pairs
      do_reset();
      step_model("wrap.seed", 1, 32'h50, 0);
      for (int i = 0; i < 10; i++) begin
         step_model($sformatf("wrap%0d", i), 1, 32'h100 + AW'(i), 1);
         chk($sformatf("wrap%0d.head", i), bus.addr, 32'h100 + AW'(i));
      end
      step_model("wrap.drain", 0, 32'h0, 1);

      // Head stability: arbiter samples addr, pushes keep arriving, pop two cycles later
      step_model("stab.push", 1, 32'h60, 0);
      held = bus.addr;
      step_model("stab.w1", 1, 32'h61, 0);
      chk("stab.hold1", bus.addr, held);
      step_model("stab.w2", 1, 32'h62, 0);
      chk("stab.hold2", bus.addr, held);
      step_model("stab.pop", 0, 32'h0, 1);

      // Asynchronous reset mid-cycle with three entries queued
      do_reset();
      step_model("mrst.p0", 1, 32'h71, 0);
      step_model("mrst.p1", 1, 32'h72, 0);
      step_model("mrst.p2", 1, 32'h73, 0);
      #3;
      aresetn = 1'b0;
      #1;
      chk("mrst.req",  AW'(bus.req),  '0);
      chk("mrst.full", AW'(bus.full), '0);
      chk("mrst.addr", bus.addr,      '0);
      #2;
      aresetn = 1'b1;
      exp_q.delete();
      ovf_m = 1'b0;
      @(posedge aclk);
      #1;
      step_model("mrst.pushB", 1, 32'hB, 0);
      chk("mrst.headB", bus.addr, 32'hB);

      // Randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step_model($sformatf("rnd%0d", i),
                    ($urandom_range(0, 99) < 60), AW'($urandom), ($urandom_range(0, 99) < 50));
      end

      // Final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
